cpu_control_sequencer: RTL and testbench

- Hardwired control unit for the 32-bit bus-based datapath.
- Sequences fetch and execute steps and drives the datapath's register-in, bus-out, ALU-op and memory control strobes, decoding the latched instruction word.
- Sits beside the datapath and consumes only its IR contents.
- Covers load/store, register ALU, immediate ALU, nop and halt.

---
 rtl/cpu_control_sequencer_pkg.sv | 82 ++++++++
 rtl/cpu_control_sequencer_if.sv | 30 +++
 rtl/cpu_control_sequencer_reg_field_decode.sv | 38 +++
 rtl/cpu_control_sequencer.sv | 128 ++++++++++++
 tb/tb_cpu_control_sequencer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_control_sequencer_pkg.sv
// ============================================================================
// cpu_isa_pkg : opcodes, ALU codes, step constants and IR field positions
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_isa_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_INC = 4'd4;

  localparam logic [3:0] T0 = 4'd0;
  localparam logic [3:0] T1 = 4'd1;
  localparam logic [3:0] T2 = 4'd2;
  localparam logic [3:0] T3 = 4'd3;
  localparam logic [3:0] T4 = 4'd4;
  localparam logic [3:0] T5 = 4'd5;
  localparam logic [3:0] T6 = 4'd6;
  localparam logic [3:0] T7 = 4'd7;
  localparam logic [3:0] T8 = 4'd8;
  localparam logic [3:0] T9 = 4'd9;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  typedef enum logic [2:0] {
    CLS_RR   = 3'd0,
    CLS_IMM  = 3'd1,
    CLS_LD   = 3'd2,
    CLS_ST   = 3'd3,
    CLS_NOP  = 3'd4,
    CLS_HALT = 3'd5,
    CLS_BAD  = 3'd6
  } op_class_e;

  function automatic op_class_e classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR:     return CLS_RR;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:  return CLS_IMM;
      OP_LD:                             return CLS_LD;
      OP_ST:                             return CLS_ST;
      OP_NOP:                            return CLS_NOP;
      OP_HALT:                           return CLS_HALT;
      default:                           return CLS_BAD;
    endcase
  endfunction

  // Loads and stores form their effective address with ADD.
  function automatic logic [3:0] alu_for(input logic [4:0] op);
    case (op)
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR,  OP_ORI:  return ALU_OR;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_control_sequencer_if.sv
// ============================================================================
// cpu_control_sequencer_if : IR/stop inputs and datapath control strobes
// Rev 1.0
// ============================================================================
`default_nettype none

interface cpu_control_sequencer_if;
  logic [31:0] ir;
  logic        stop;
  logic        PCout, MDRout, Zlowout, Cout;
  logic        PCin, IRin, Yin, MARin, MDRin;
  logic        Read, enable;
  logic [3:0]  alu_op;
  logic [15:0] reg_in, reg_out;
  logic        running, illegal;

  modport master (
    input  ir, stop,
    output PCout, MDRout, Zlowout, Cout, PCin, IRin, Yin, MARin, MDRin,
           Read, enable, alu_op, reg_in, reg_out, running, illegal
  );

  modport slave (
    output ir, stop,
    input  PCout, MDRout, Zlowout, Cout, PCin, IRin, Yin, MARin, MDRin,
           Read, enable, alu_op, reg_in, reg_out, running, illegal
  );
endinterface

`default_nettype wire

// File: rtl/cpu_control_sequencer_reg_field_decode.sv
// ============================================================================
// reg_field_decode : turns the selected IR register field into one-hot enables
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_field_decode
  import cpu_isa_pkg::*;
(
  input  logic [31:0] ir,
  input  logic        gra,
  input  logic        grb,
  input  logic        grc,
  input  logic        rin,
  input  logic        rout,
  output logic [15:0] reg_in,
  output logic [15:0] reg_out
);

  logic [3:0]  sel;
  logic [15:0] onehot;
  logic        unused_ir_bits;

  assign unused_ir_bits = ^{ir[OPC_MSB:OPC_LSB], ir[RC_LSB-1:0]};

  always_comb begin
    sel = 4'd0;
    if (gra)      sel = ir[RA_MSB:RA_LSB];
    else if (grb) sel = ir[RB_MSB:RB_LSB];
    else if (grc) sel = ir[RC_MSB:RC_LSB];
    onehot  = (gra | grb | grc) ? (16'd1 << sel) : 16'd0;
    reg_in  = rin  ? onehot : 16'd0;
    reg_out = rout ? onehot : 16'd0;
  end

endmodule

`default_nettype wire

// File: rtl/cpu_control_sequencer.sv
// ============================================================================
// cpu_control_sequencer : hardwired T0..T9 fetch/execute control unit
// Rev 1.0
// ============================================================================
`default_nettype none

module cpu_control_sequencer
  import cpu_isa_pkg::*;
#(
  parameter int         NSTEPS    = 10,
  parameter logic [3:0] PC_INC_OP = 4'd4
) (
  input  logic                     clock,
  input  logic                     clear,
  cpu_control_sequencer_if.master  bus
);

  logic [3:0] step_q, step_d;
  logic       halted_q, halted_d;

  logic       active;
  logic [4:0] op;
  op_class_e  cls;
  logic       last, go_halt;
  logic       pc_out, mdr_out, zlow_out, c_out;
  logic       pc_in, ir_in, y_in, mar_in, mdr_in, rd, en, bad;
  logic [3:0] alu;
  logic       gra, grb, grc, rin, rout;

  assign active = clear & ~halted_q;
  assign op     = bus.ir[OPC_MSB:OPC_LSB];
  assign cls    = classify(op);

  always_comb begin
    pc_out = 1'b0; mdr_out = 1'b0; zlow_out = 1'b0; c_out = 1'b0;
    pc_in  = 1'b0; ir_in   = 1'b0; y_in     = 1'b0; mar_in = 1'b0;
    mdr_in = 1'b0; rd      = 1'b0; en       = 1'b0; bad    = 1'b0;
    alu    = 4'd0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; rin = 1'b0; rout = 1'b0;
    last    = 1'b0;
    go_halt = 1'b0;

    case (step_q)
      T0: begin pc_out = 1'b1; mar_in = 1'b1; alu = PC_INC_OP; end
      T1: begin zlow_out = 1'b1; pc_in = 1'b1; end
      T2: begin rd = 1'b1; mdr_in = 1'b1; end
      T3: begin
        mdr_out = 1'b1; ir_in = 1'b1;
        if (cls == CLS_NOP || cls == CLS_BAD) last = 1'b1;
        if (cls == CLS_BAD) bad = 1'b1;
        if (cls == CLS_HALT) go_halt = 1'b1;
      end
      T4: begin grb = 1'b1; rout = 1'b1; y_in = 1'b1; end
      T5: begin
        alu = alu_for(op);
        if (cls == CLS_RR) begin grc = 1'b1; rout = 1'b1; end
        else c_out = 1'b1;
      end
      T6: begin
        zlow_out = 1'b1;
        if (cls == CLS_RR || cls == CLS_IMM) begin gra = 1'b1; rin = 1'b1; last = 1'b1; end
        else mar_in = 1'b1;
      end
      T7: if (cls == CLS_ST) begin gra = 1'b1; rout = 1'b1; mdr_in = 1'b1; end
      T8: begin
        if (cls == CLS_LD) begin rd = 1'b1; mdr_in = 1'b1; end
        if (cls == CLS_ST) begin en = 1'b1; last = 1'b1; end
      end
      T9: if (cls == CLS_LD) begin mdr_out = 1'b1; gra = 1'b1; rin = 1'b1; end
      default: ;
    endcase

    // Final step (or an out-of-range step) always returns to T0.
    if (step_q >= 4'(NSTEPS - 1)) last = 1'b1;

    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (go_halt || (last && bus.stop)) begin
        halted_d = 1'b1;
        step_d   = T0;
      end else if (last) begin
        step_d = T0;
      end else begin
        step_d = step_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  assign bus.PCout   = active & pc_out;
  assign bus.MDRout  = active & mdr_out;
  assign bus.Zlowout = active & zlow_out;
  assign bus.Cout    = active & c_out;
  assign bus.PCin    = active & pc_in;
  assign bus.IRin    = active & ir_in;
  assign bus.Yin     = active & y_in;
  assign bus.MARin   = active & mar_in;
  assign bus.MDRin   = active & mdr_in;
  assign bus.Read    = active & rd;
  assign bus.enable  = active & en;
  assign bus.alu_op  = active ? alu : 4'd0;
  assign bus.running = active;
  assign bus.illegal = active & bad;

  reg_field_decode u_reg_decode (
    .ir      (bus.ir),
    .gra     (gra),
    .grb     (grb),
    .grc     (grc),
    .rin     (rin & active),
    .rout    (rout & active),
    .reg_in  (bus.reg_in),
    .reg_out (bus.reg_out)
  );

endmodule

`default_nettype wire

// File: tb/tb_cpu_control_sequencer.sv
// ============================================================================
// tb_cpu_control_sequencer : directed plus random instruction streams
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cpu_control_sequencer;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  cpu_control_sequencer_if ifc ();

  cpu_control_sequencer #(.NSTEPS(10), .PC_INC_OP(4'd4)) dut (
    .clock (clk),
    .clear (clear),
    .bus   (ifc.master)
  );

  typedef struct packed {
    logic pc_out, mdr_out, zlow_out, c_out, pc_in, ir_in, y_in, mar_in, mdr_in, rd, en;
    logic [3:0]  alu;
    logic [15:0] rin, rout;
    logic run, ill;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t idle_obs();
    obs_t o = '0;
    o.run = 1'b1;
    return o;
  endfunction

  function automatic obs_t observe();
    return {ifc.PCout, ifc.MDRout, ifc.Zlowout, ifc.Cout, ifc.PCin, ifc.IRin, ifc.Yin,
            ifc.MARin, ifc.MDRin, ifc.Read, ifc.enable, ifc.alu_op, ifc.reg_in,
            ifc.reg_out, ifc.running, ifc.illegal};
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op, input int ra, input int rb,
                                     input int rc, input int imm);
    return {op, 4'(ra), 4'(rb), 4'(rc), 15'(imm)};
  endfunction

  task automatic check(input string tag, input int cyc, input obs_t expv);
    obs_t got;
    got = observe();
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s cyc%0d: observed %h expected %h", tag, cyc, got, expv);
    end
  endtask

  // Expected per-cycle strobes for one instruction, listed straight from the
  // instruction's micro-step table.
  task automatic plan(input logic [31:0] w, output bit halts);
    obs_t e;
    logic [4:0]  op;
    logic [15:0] a, b, c;
    bit known;
    op = w[31:27];
    a = 16'd1 << w[26:23];
    b = 16'd1 << w[22:19];
    c = 16'd1 << w[18:15];
    halts = (op == 5'b11011);
    known = (op <= 5'd6) || (op == 5'd12) || (op == 5'd13) || (op == 5'd14) ||
            (op == 5'd26) || (op == 5'd27);
    exp_q.delete();
    e = idle_obs(); e.pc_out = 1; e.mar_in = 1; e.alu = 4'd4; exp_q.push_back(e);
    e = idle_obs(); e.zlow_out = 1; e.pc_in = 1;             exp_q.push_back(e);
    e = idle_obs(); e.rd = 1; e.mdr_in = 1;                  exp_q.push_back(e);
    e = idle_obs(); e.mdr_out = 1; e.ir_in = 1; e.ill = !known; exp_q.push_back(e);
    if (op >= 5'd3 && op <= 5'd6) begin
      e = idle_obs(); e.rout = b; e.y_in = 1;               exp_q.push_back(e);
      e = idle_obs(); e.rout = c; e.alu = 4'(op - 5'd3);    exp_q.push_back(e);
      e = idle_obs(); e.zlow_out = 1; e.rin = a;            exp_q.push_back(e);
    end else if (op == 5'd1 || (op >= 5'd12 && op <= 5'd14) || op == 5'd0 || op == 5'd2) begin
      e = idle_obs(); e.rout = b; e.y_in = 1;               exp_q.push_back(e);
      e = idle_obs(); e.c_out = 1;
      e.alu = (op == 5'd13) ? 4'd2 : (op == 5'd14) ? 4'd3 : 4'd0;
      exp_q.push_back(e);
      e = idle_obs(); e.zlow_out = 1;
      if (op == 5'd0 || op == 5'd2) e.mar_in = 1; else e.rin = a;
      exp_q.push_back(e);
      if (op == 5'd0) begin
        e = idle_obs();                                     exp_q.push_back(e);
        e = idle_obs(); e.rd = 1; e.mdr_in = 1;             exp_q.push_back(e);
        e = idle_obs(); e.mdr_out = 1; e.rin = a;           exp_q.push_back(e);
      end else if (op == 5'd2) begin
        e = idle_obs(); e.rout = a; e.mdr_in = 1;           exp_q.push_back(e);
        e = idle_obs(); e.en = 1;                           exp_q.push_back(e);
      end
    end
  endtask

  // stop is raised at cycle stop_from (held); clear drops at cycle abort_at.
  task automatic run_instr(input string tag, input logic [31:0] w, input int stop_from,
                           input int abort_at, output bit halted);
    bit halts;
    plan(w, halts);
    halted = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      clear    = 1'b1;
      ifc.ir   = w;
      ifc.stop = (stop_from >= 0) && (i >= stop_from);
      if (i == abort_at) begin
        clear = 1'b0;
        #1;
        check(tag, i, '0);
        return;
      end
      #1;
      check(tag, i, exp_q[i]);
    end
    halted = halts || ((stop_from >= 0) && (stop_from <= exp_q.size() - 1));
  endtask

  task automatic halted_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ifc.ir   = $urandom;
      ifc.stop = 1'($urandom);
      #1;
      check(tag, i, '0);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clear    = 1'b0;
      ifc.stop = 1'b0;
      #1;
      check("reset", i, '0);
    end
  endtask

  logic [4:0] ops [13] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
                           5'd12, 5'd13, 5'd14, 5'd26, 5'd27, 5'd21};

  initial begin
    bit h;
    logic [31:0] w;
    int sf;
    clear    = 1'b0;
    ifc.ir   = 32'd0;
    ifc.stop = 1'b0;

    do_reset(2);
    run_instr("add", 32'h19880000, -1, -1, h);
    run_instr("ld", 32'h02900010, -1, -1, h);
    run_instr("st", 32'h12080000, -1, -1, h);
    run_instr("addi_same", mk(5'd12, 7, 7, 7, 5), -1, -1, h);
    run_instr("sub_same", mk(5'd4, 0, 0, 0, 0), -1, -1, h);
    run_instr("nop", mk(5'd26, 1, 2, 3, 0), -1, -1, h);
    run_instr("illegal", mk(5'd31, 1, 2, 3, 0), -1, -1, h);
    run_instr("ld_abort", 32'h02900010, -1, 7, h);
    run_instr("after_abort", mk(5'd26, 0, 0, 0, 0), -1, -1, h);

    run_instr("add_stop", 32'h19880000, 5, -1, h);
    assert (h) else begin errors++; $error("FAIL add_stop_model: observed 0 expected 1"); end
    checks++;
    halted_idle("add_stop_halted", 5);
    do_reset(1);

    run_instr("halt", 32'hD8000000, -1, -1, h);
    halted_idle("halt_idle", 20);
    do_reset(2);

    for (int n = 0; n < 40; n++) begin
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[31:27] = ops[$urandom_range(0, 12)];
      sf = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 9)) : -1;
      run_instr("rand", w, sf, -1, h);
      if (h) begin
        halted_idle("rand_halted", 3);
        do_reset(1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
